// File: rtl/pagerank_pkg.sv
// ============================================================================
// Module   : pagerank_pkg
// Purpose  : Shared types and helpers for the PageRank graph loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pagerank_pkg;

  // Node identifiers are plain unsigned 32-bit values.
  typedef logic [31:0] node_id_t;

  // Loader control states.
  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_CLEAR = 2'd1,
    LD_LOAD  = 2'd2,
    LD_DONE  = 2'd3
  } loader_state_e;

  // Location of a node inside the partitioned tables.
  typedef struct packed {
    node_id_t partition;
    node_id_t index;
  } node_addr_t;

  // Split a global node id into (partition, index within partition).
  function automatic node_addr_t decode_addr(input node_id_t src, input node_id_t nodes_in_part);
    node_addr_t a;
    a.partition = src / nodes_in_part;
    a.index     = src % nodes_in_part;
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pagerank_dup_check.sv
// ============================================================================
// Module   : pagerank_dup_check
// Purpose  : Combinational check whether a destination id already occupies
//            one of the first count_i slots of an adjacency row.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pagerank_dup_check
  import pagerank_pkg::*;
#(
  parameter int MAX_DEGREE = 3
) (
  input  node_id_t row_i [MAX_DEGREE],
  input  node_id_t count_i,
  input  node_id_t dst_i,
  output logic     dup_o
);

  // Only slots below the current degree hold real edges; the rest are zero.
  always_comb begin
    dup_o = 1'b0;
    for (int s = 0; s < MAX_DEGREE; s++) begin
      if ((node_id_t'(s) < count_i) && (row_i[s] == dst_i)) begin
        dup_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pagerank_graph_loader.sv
// ============================================================================
// Module   : pagerank_graph_loader
// Purpose  : Streams an edge list into partitioned adjacency tables for the
//            serial PageRank engine and raises pagerank_enable when done.
//            Optional macro PAGERANK_LOADER_DEDUP_EN drops duplicate edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pagerank_graph_loader
  import pagerank_pkg::*;
#(
  parameter int NUM_PARTITIONS     = 1,
  parameter int NODES_IN_PARTITION = 4,
  parameter int MAX_DEGREE         = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start,
  input  logic        edge_valid,
  output logic        edge_ready,
  input  logic [31:0] edge_src,
  input  logic [31:0] edge_dst,
  input  logic        edge_last,
  output logic [31:0] source_id  [NUM_PARTITIONS][NODES_IN_PARTITION],
  output logic [31:0] out_degree [NUM_PARTITIONS][NODES_IN_PARTITION],
  output logic [31:0] dest_id    [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_DEGREE],
  output logic        pagerank_enable,
  output logic [31:0] edge_count,
  output logic        range_err,
  output logic        overflow_err
);

  localparam logic [1:0] ST_IDLE  = LD_IDLE;
  localparam logic [1:0] ST_CLEAR = LD_CLEAR;
  localparam logic [1:0] ST_LOAD  = LD_LOAD;
  localparam logic [1:0] ST_DONE  = LD_DONE;

  localparam node_id_t NUM_NODES = node_id_t'(NUM_PARTITIONS * NODES_IN_PARTITION);
  localparam node_id_t DEG_MAX   = node_id_t'(MAX_DEGREE);
  localparam node_id_t NIP       = node_id_t'(NODES_IN_PARTITION);

  logic [1:0] state_q, state_d;
  logic       ready_q;
  logic       enable_q;
  node_id_t   count_q;
  logic       rerr_q;
  logic       oerr_q;
  node_id_t   src_q [NUM_PARTITIONS][NODES_IN_PARTITION];
  node_id_t   deg_q [NUM_PARTITIONS][NODES_IN_PARTITION];
  node_id_t   dst_q [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_DEGREE];

  logic       w_accept;
  logic       w_in_range;
  logic       w_full;
  logic       w_dup;
  logic       w_store;
  node_addr_t w_addr;
  node_id_t   w_k;
  logic       w_hit [NUM_PARTITIONS][NODES_IN_PARTITION];

  // Decode the incoming beat and fetch the current degree of the addressed row.
  always_comb begin
    w_accept   = edge_valid && ready_q;
    w_addr     = decode_addr(edge_src, NIP);
    w_in_range = (edge_src < NUM_NODES) && (edge_dst < NUM_NODES);
    w_k        = '0;
    for (int p = 0; p < NUM_PARTITIONS; p++) begin
      for (int i = 0; i < NODES_IN_PARTITION; i++) begin
        w_hit[p][i] = (w_addr.partition == node_id_t'(p)) && (w_addr.index == node_id_t'(i));
        if (w_hit[p][i]) begin
          w_k = deg_q[p][i];
        end
      end
    end
    w_full = (w_k >= DEG_MAX);
  end

`ifdef PAGERANK_LOADER_DEDUP_EN
  node_id_t w_row [MAX_DEGREE];

  // Select the addressed row so its filled slots can be searched for dst.
  always_comb begin
    for (int s = 0; s < MAX_DEGREE; s++) begin
      w_row[s] = '0;
    end
    for (int p = 0; p < NUM_PARTITIONS; p++) begin
      for (int i = 0; i < NODES_IN_PARTITION; i++) begin
        if (w_hit[p][i]) begin
          w_row = dst_q[p][i];
        end
      end
    end
  end

  pagerank_dup_check #(
    .MAX_DEGREE (MAX_DEGREE)
  ) u_dup_check (
    .row_i   (w_row),
    .count_i (w_k),
    .dst_i   (edge_dst),
    .dup_o   (w_dup)
  );
`else
  assign w_dup = 1'b0;
`endif

  // Range errors win, then silent duplicate drops, then overflow; a duplicate
  // in a full row is treated as a duplicate rather than an overflow.
  assign w_store = w_accept && w_in_range && !w_dup && !w_full;

  // Next-state logic for the load sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_LOAD;
      ST_LOAD:  if (w_accept && edge_last) state_d = ST_DONE;
      ST_DONE:  if (load_start) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers: handshake, completion flag, counters and sticky errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      count_q  <= '0;
      rerr_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_start) enable_q <= 1'b0;
        end
        ST_CLEAR: begin
          ready_q <= 1'b1;
          count_q <= '0;
          rerr_q  <= 1'b0;
          oerr_q  <= 1'b0;
        end
        ST_LOAD: begin
          if (w_store) count_q <= count_q + 32'd1;
          if (w_accept && !w_in_range) rerr_q <= 1'b1;
          if (w_accept && w_in_range && !w_dup && w_full) oerr_q <= 1'b1;
          if (w_accept && edge_last) begin
            ready_q  <= 1'b0;
            enable_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Adjacency tables: initialised on reset/CLEAR, appended on each stored edge.
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PARTITIONS; p++) begin
      for (int i = 0; i < NODES_IN_PARTITION; i++) begin
        if (reset || (state_q == ST_CLEAR)) begin
          src_q[p][i] <= node_id_t'(p * NODES_IN_PARTITION + i);
          deg_q[p][i] <= '0;
          for (int s = 0; s < MAX_DEGREE; s++) begin
            dst_q[p][i][s] <= '0;
          end
        end else if ((state_q == ST_LOAD) && w_store && w_hit[p][i]) begin
          deg_q[p][i] <= deg_q[p][i] + 32'd1;
          for (int s = 0; s < MAX_DEGREE; s++) begin
            if (node_id_t'(s) == w_k) dst_q[p][i][s] <= edge_dst;
          end
        end
      end
    end
  end

  assign edge_ready      = ready_q;
  assign pagerank_enable = enable_q;
  assign edge_count      = count_q;
  assign range_err       = rerr_q;
  assign overflow_err    = oerr_q;
  assign source_id       = src_q;
  assign out_degree      = deg_q;
  assign dest_id         = dst_q;

endmodule

`default_nettype wire

// File: tb/tb_pagerank_graph_loader.sv
// ============================================================================
// Module   : tb_pagerank_graph_loader
// Purpose  : Scoreboard bench for pagerank_graph_loader (1 partition x 4
//            nodes, 3 slots). Expected tables are pushed per load; a monitor
//            pops and compares them when pagerank_enable rises.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pagerank_graph_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic        edge_valid;
  logic        edge_ready;
  logic [31:0] edge_src;
  logic [31:0] edge_dst;
  logic        edge_last;
  logic [31:0] source_id  [1][4];
  logic [31:0] out_degree [1][4];
  logic [31:0] dest_id    [1][4][3];
  logic        pagerank_enable;
  logic [31:0] edge_count;
  logic        range_err;
  logic        overflow_err;

  typedef struct packed {
    logic [3:0][31:0]      deg;
    logic [3:0][2:0][31:0] dst;
    logic [31:0]           cnt;
    logic                  rerr;
    logic                  oerr;
  } exp_t;

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] d;
  } edge_t;

  exp_t  sb[$];
  edge_t edges[$];
  exp_t  e;
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  en_prev  = 1'b0;

  pagerank_graph_loader #(
    .NUM_PARTITIONS     (1),
    .NODES_IN_PARTITION (4),
    .MAX_DEGREE         (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .load_start      (load_start),
    .edge_valid      (edge_valid),
    .edge_ready      (edge_ready),
    .edge_src        (edge_src),
    .edge_dst        (edge_dst),
    .edge_last       (edge_last),
    .source_id       (source_id),
    .out_degree      (out_degree),
    .dest_id         (dest_id),
    .pagerank_enable (pagerank_enable),
    .edge_count      (edge_count),
    .range_err       (range_err),
    .overflow_err    (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: each rising pagerank_enable is one finished load to score.
  always @(negedge clock) begin
    exp_t x;
    if (!reset && pagerank_enable && !en_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("out_degree[%0d]", i), out_degree[0][i], x.deg[i]);
          for (int s = 0; s < 3; s++)
            chk($sformatf("dest_id[%0d][%0d]", i, s), dest_id[0][i][s], x.dst[i][s]);
        end
        chk("edge_count", edge_count, x.cnt);
        chk("range_err", {31'd0, range_err}, {31'd0, x.rerr});
        chk("overflow_err", {31'd0, overflow_err}, {31'd0, x.oerr});
      end
    end
    en_prev = pagerank_enable;
  end

  task automatic check_reset_values();
    chk("rst_edge_ready", {31'd0, edge_ready}, 32'd0);
    chk("rst_enable", {31'd0, pagerank_enable}, 32'd0);
    chk("rst_range_err", {31'd0, range_err}, 32'd0);
    chk("rst_overflow_err", {31'd0, overflow_err}, 32'd0);
    chk("rst_edge_count", edge_count, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_source_id[%0d]", i), source_id[0][i], 32'(i));
      chk($sformatf("rst_out_degree[%0d]", i), out_degree[0][i], 32'd0);
      for (int s = 0; s < 3; s++)
        chk($sformatf("rst_dest_id[%0d][%0d]", i, s), dest_id[0][i][s], 32'd0);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
    chk("clear_ready_low", {31'd0, edge_ready}, 32'd0);
    chk("clear_enable_low", {31'd0, pagerank_enable}, 32'd0);
    @(posedge clock); #1;
    chk("load_ready_high", {31'd0, edge_ready}, 32'd1);
  endtask

  task automatic send_edge(input logic [31:0] s, input logic [31:0] d, input bit last, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    end
    edge_valid = 1'b1; edge_src = s; edge_dst = d; edge_last = last;
    n = 0;
    while (!edge_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (!edge_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      edge_valid = 1'b0; edge_last = 1'b0;
    end else begin
      @(posedge clock); #1;
      edge_valid = 1'b0; edge_last = 1'b0;
    end
  endtask

  // Send the queued edge list as one load; last flag on the final edge.
  task automatic run_load(input bit gaps);
    start_load();
    for (int j = 0; j < edges.size(); j++)
      send_edge(edges[j].s, edges[j].d, j == edges.size() - 1, gaps);
    chk("enable_after_last", {31'd0, pagerank_enable}, 32'd1);
    chk("ready_after_last", {31'd0, edge_ready}, 32'd0);
    @(posedge clock); #1;
  endtask

  function automatic edge_t mk(input int s, input int d);
    edge_t t;
    t.s = 32'(s); t.d = 32'(d);
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; edge_valid = 1'b0;
    edge_src = '0; edge_dst = '0; edge_last = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    reset = 1'b0;
    @(posedge clock); #1;

    // Full reference graph, back to back, then with random valid gaps.
    e = '0;
    e.deg[0] = 2; e.deg[1] = 1; e.deg[2] = 3; e.deg[3] = 1;
    e.dst[0][0] = 1; e.dst[0][1] = 2;
    e.dst[1][0] = 3;
    e.dst[2][0] = 0; e.dst[2][1] = 1; e.dst[2][2] = 3;
    e.dst[3][0] = 2;
    e.cnt = 7;
    edges = '{mk(0,1), mk(0,2), mk(1,3), mk(2,0), mk(2,1), mk(2,3), mk(3,2)};
    sb.push_back(e);
    run_load(1'b0);
    sb.push_back(e);
    run_load(1'b1);

    // Out-of-range source is dropped and flagged.
    e = '0;
    e.deg[0] = 1; e.deg[1] = 1;
    e.dst[0][0] = 1; e.dst[1][0] = 2;
    e.cnt = 2; e.rerr = 1'b1;
    edges = '{mk(0,1), mk(5,1), mk(1,2)};
    sb.push_back(e);
    run_load(1'b0);

    // Fourth edge into a full row overflows; range flag from before is cleared.
    e = '0;
    e.deg[2] = 3;
    e.dst[2][0] = 0; e.dst[2][1] = 1; e.dst[2][2] = 3;
    e.cnt = 3; e.oerr = 1'b1;
    edges = '{mk(2,0), mk(2,1), mk(2,3), mk(2,2)};
    sb.push_back(e);
    run_load(1'b0);

    // Duplicate edge.
    e = '0;
`ifdef PAGERANK_LOADER_DEDUP_EN
    e.deg[0] = 1; e.dst[0][0] = 1; e.cnt = 1;
`else
    e.deg[0] = 2; e.dst[0][0] = 1; e.dst[0][1] = 1; e.cnt = 2;
`endif
    edges = '{mk(0,1), mk(0,1)};
    sb.push_back(e);
    run_load(1'b0);

    // Reset in the middle of a load, then a fresh small load.
    start_load();
    send_edge(32'd0, 32'd1, 1'b0, 1'b0);
    send_edge(32'd1, 32'd2, 1'b0, 1'b0);
    send_edge(32'd2, 32'd3, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_values();
    reset = 1'b0;
    @(posedge clock); #1;
    e = '0;
    e.deg[1] = 1; e.deg[3] = 1;
    e.dst[1][0] = 2; e.dst[3][0] = 1;
    e.cnt = 2;
    edges = '{mk(3,1), mk(1,2)};
    sb.push_back(e);
    run_load(1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
